// File: rtl/compress_pack_ctrl_if.sv
// Stream bundle for the float-to-byte packer: sample input side and packed
// word output side, each with its own valid/ready handshake.
interface compress_pack_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_bytes;
    logic        out_last;

    // Producer of samples / consumer of packed words.
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_bytes, out_last
    );

    // The packer itself.
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_bytes, out_last
    );
endinterface

// File: rtl/compress_pack_ctrl.sv
// Compresses IEEE-754 single-precision samples to one byte each and packs up
// to four of them into a 32-bit word. A word closes after the fourth lane or
// on a sample flagged in_last; unfilled lanes carry PAD_BYTE. One-deep output
// register with full-throughput valid/ready handshake.
module compress_pack_ctrl #(
    parameter logic [7:0] PAD_BYTE = 8'h00,
    parameter int         CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    compress_pack_ctrl_if.slave  bus,
    output logic [CNT_W-1:0]     word_count
);

    typedef enum logic {
        EMPTY   = 1'b0,
        PARTIAL = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] acc_p0, acc_d;
    logic [31:0] word_d;
    logic [7:0]  byte_new;
    logic        xfer;
    logic        close;

    // Byte = {sign, bits 22:16 of the hidden-one mantissa shifted right by
    // (127 - exponent) mod 256}. Exponents above 127 wrap to a large shift
    // and therefore yield a zero magnitude, as do zero/denormal inputs.
    function automatic logic [7:0] compress_byte(input logic [31:0] s);
        logic [7:0]  shift;
        logic [23:0] m;
        shift = 8'(8'd127 - s[30:23]);
        if (shift >= 8'd24)
            m = '0;
        else
            m = {1'b1, s[22:0]} >> shift;
        return {s[31], m[22:16]};
    endfunction

    // Accept whenever the output register is free or being drained this cycle.
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign xfer         = bus.in_valid && bus.in_ready;
    assign byte_new     = compress_byte(bus.in_data);

    // Lane accumulation, word assembly and next-state decision.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        acc_d   = acc_p0;
        close   = 1'b0;
        word_d  = '0;

        for (int i = 0; i < 4; i++) begin
            if (2'(i) < lane_q)
                word_d[8*i +: 8] = acc_p0[8*i +: 8];
            else if (2'(i) == lane_q)
                word_d[8*i +: 8] = byte_new;
            else
                word_d[8*i +: 8] = PAD_BYTE;
        end

        case (state_q)
            EMPTY, PARTIAL: begin
                if (xfer) begin
                    if (lane_q == 2'd3 || bus.in_last) begin
                        close   = 1'b1;
                        lane_d  = 2'd0;
                        acc_d   = '0;
                        state_d = EMPTY;
                    end else begin
                        acc_d[{lane_q, 3'b000} +: 8] = byte_new;
                        lane_d  = lane_q + 2'd1;
                        state_d = PARTIAL;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
                lane_d  = 2'd0;
                acc_d   = '0;
            end
        endcase
    end

    // Accumulator stage: FSM state, lane counter and partial-word bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            lane_q  <= 2'd0;
            acc_p0  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            acc_p0  <= acc_d;
        end
    end

    // Output stage: load a closed word (even while the old one drains), else
    // drop valid once the downstream handshake completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_bytes <= '0;
            bus.out_last  <= 1'b0;
        end else if (close) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= word_d;
            bus.out_bytes <= 3'(lane_q) + 3'd1;
            bus.out_last  <= bus.in_last;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    // Delivered-word counter, sticks at all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            word_count <= '0;
        else if (bus.out_valid && bus.out_ready && (word_count != {CNT_W{1'b1}}))
            word_count <= word_count + 1'b1;
    end

endmodule

// File: tb/tb_compress_pack_ctrl.sv
// Directed bench for compress_pack_ctrl: expected words are pushed into a
// scoreboard when stimulus is issued, and a monitor pops and compares on every
// output handshake.
module tb_compress_pack_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] word_count;

    compress_pack_ctrl_if bus ();

    compress_pack_ctrl #(
        .PAD_BYTE (8'h00),
        .CNT_W    (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  bytes;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_wc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [2:0] b, input logic l);
        exp_t e;
        e.data  = d;
        e.bytes = b;
        e.last  = l;
        sb.push_back(e);
    endtask

    // Monitor: every output handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got 0x%08h expected no word", bus.out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data",  bus.out_data,        e.data);
                check("out_bytes", 32'(bus.out_bytes),  32'(e.bytes));
                check("out_last",  32'(bus.out_last),   32'(e.last));
            end
            check("word_count_at_hs", 32'(word_count), 32'(exp_wc));
            exp_wc++;
        end
    end

    task automatic send(input logic [31:0] d, input logic last);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 200 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int cycles);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (cycles) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out_valid"},  32'(bus.out_valid),  32'd0);
        check({tag, "_out_data"},   bus.out_data,        32'd0);
        check({tag, "_out_bytes"},  32'(bus.out_bytes),  32'd0);
        check({tag, "_out_last"},   32'(bus.out_last),   32'd0);
        check({tag, "_word_count"}, 32'(word_count),     32'd0);
        check({tag, "_in_ready"},   32'(bus.in_ready),   32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        #2;
        check_zero_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // Full word, latency of one cycle after the fourth transfer.
        push(32'hC0206040, 3'd4, 1'b0);
        send(32'h3F000000, 1'b0);
        send(32'h3F400000, 1'b0);
        send(32'h3E800000, 1'b0);
        check("no_early_word", 32'(bus.out_valid), 32'd0);
        send(32'hBF000000, 1'b0);
        check("latency_valid", 32'(bus.out_valid), 32'd1);
        idle(2);

        // Two-lane word closed by in_last.
        push(32'h00006040, 3'd2, 1'b1);
        send(32'h3F000000, 1'b0);
        send(32'h3F400000, 1'b1);
        idle(2);

        // Exponent wrap and special encodings all compress to zero.
        push(32'h00000000, 3'd4, 1'b0);
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b0);
        send(32'h00000000, 1'b0);
        send(32'h7F800000, 1'b0);
        idle(2);

        // in_last without in_valid must not close a word.
        bus.in_last = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("stray_last", 32'(bus.out_valid), 32'd0);
        bus.in_last = 1'b0;

        // Single-lane word: lane 0 closes with in_last.
        push(32'h00000040, 3'd1, 1'b1);
        send(32'h3F000000, 1'b1);
        idle(2);

        // Backpressure: word held stable and input stalled.
        bus.out_ready = 1'b0;
        push(32'h40602040, 3'd4, 1'b0);
        send(32'h3F000000, 1'b0);
        send(32'h3E800000, 1'b0);
        send(32'h3F400000, 1'b0);
        send(32'h3F000000, 1'b0);
        idle(0);
        for (int c = 0; c < 10; c++) begin
            check("stall_in_ready",  32'(bus.in_ready),  32'd0);
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_out_data",  bus.out_data,       32'h40602040);
            check("stall_out_bytes", 32'(bus.out_bytes), 32'd4);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_release_count", 32'(word_count), 32'(exp_wc));
        check("stall_release_valid", 32'(bus.out_valid), 32'd0);

        // Eight samples at full rate: two words, no lane lost or repeated.
        push(32'hC0206040, 3'd4, 1'b0);
        push(32'h60406040, 3'd4, 1'b0);
        send(32'h3F000000, 1'b0);
        send(32'h3F400000, 1'b0);
        send(32'h3E800000, 1'b0);
        send(32'hBF000000, 1'b0);
        send(32'h3F000000, 1'b0);
        send(32'h3F400000, 1'b0);
        send(32'h3F000000, 1'b0);
        send(32'h3F400000, 1'b0);
        idle(2);

        // Back-to-back single-lane words: new word loads on the drain edge.
        push(32'h00000040, 3'd1, 1'b1);
        push(32'h00000060, 3'd1, 1'b1);
        push(32'h000000C0, 3'd1, 1'b1);
        send(32'h3F000000, 1'b1);
        send(32'h3F400000, 1'b1);
        check("b2b_valid", 32'(bus.out_valid), 32'd1);
        check("b2b_data",  bus.out_data,       32'h00000060);
        send(32'hBF000000, 1'b1);
        idle(2);

        // Reset mid-word discards the partial lanes and zeroes outputs.
        send(32'hBF000000, 1'b0);
        send(32'hBF000000, 1'b0);
        idle(0);
        rst_n = 1'b0;
        #1;
        exp_wc = 0;
        check_zero_outputs("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        push(32'h40206040, 3'd4, 1'b0);
        send(32'h3F000000, 1'b0);
        send(32'h3F400000, 1'b0);
        send(32'h3E800000, 1'b0);
        check("fresh_no_early", 32'(bus.out_valid), 32'd0);
        send(32'h3F000000, 1'b0);
        idle(3);

        check("sb_drained",       32'(sb.size()),  32'd0);
        check("final_word_count", 32'(word_count), 32'(exp_wc));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
